// File: rtl/adder_display_sequencer_if.sv
// Bundles the key/switch inputs and display/status outputs of the adder sequencer.
// Latency: none, signal container only.
// Backpressure: none; the board side drives the inputs, the sequencer drives the outputs.
interface adder_display_sequencer_if #(
  parameter int WIDTH = 3
);
  logic             key_n;
  logic [WIDTH-1:0] sw_a;
  logic [WIDTH-1:0] sw_b;
  logic             cin;
  logic [0:6]       HEX1;
  logic [0:6]       HEX0;
  logic [1:0]       phase;
  logic             busy;
  logic             done;

  // Board / testbench side
  modport master (
    output key_n, sw_a, sw_b, cin,
    input  HEX1, HEX0, phase, busy, done
  );

  // Sequencer side
  modport slave (
    input  key_n, sw_a, sw_b, cin,
    output HEX1, HEX0, phase, busy, done
  );
endinterface

// File: rtl/adder_display_sequencer.sv
// Captures A, then B+cin on debounced key presses, converts the sum to BCD and drives two 7-seg digits.
// Latency: press visible DEBOUNCE_CYCLES+3 cycles after key goes low; conversion takes floor(sum/10)+1 cycles.
// Backpressure: none; presses arriving during conversion are dropped, not queued.
module adder_display_sequencer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      resetn,
  adder_display_sequencer_if.slave  bus
);

  localparam int RW = WIDTH + 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    GET_B   = 2'd1,
    CONVERT = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t         state;
  logic           key_s1, key_s2;
  logic           key_deb;
  logic [CW-1:0]  deb_cnt;
  logic           press;
  logic [WIDTH-1:0] op_a, op_b;
  logic           c_reg;
  logic [RW-1:0]  rem;
  logic [2:0]     tens;
  logic [7:0]     rem_ext;
  logic [0:6]     hex1_q, hex0_q;
  logic           busy_q, done_q;

  assign rem_ext   = 8'(rem);
  assign bus.HEX1  = hex1_q;
  assign bus.HEX0  = hex0_q;
  assign bus.phase = state;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // Digit to active-low segments a..g; anything outside 0..9 blanks the digit
  function automatic logic [0:6] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous pushbutton
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= bus.key_n;
      key_s2 <= key_s1;
    end
  end

  // Debounce: flip the accepted level after a run of disagreeing samples; pulse press on 1->0 only
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      deb_cnt <= '0;
      key_deb <= 1'b1;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_s2 == key_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        deb_cnt <= '0;
        key_deb <= key_s2;
        press   <= key_deb;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Sequencer FSM with capture, repeated-subtraction BCD conversion and display registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= GET_A;
      op_a   <= '0;
      op_b   <= '0;
      c_reg  <= 1'b0;
      rem    <= '0;
      tens   <= '0;
      hex1_q <= SEG_BLANK;
      hex0_q <= SEG_BLANK;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        GET_A: begin
          if (press) begin
            op_a  <= bus.sw_a;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (press) begin
            op_b   <= bus.sw_b;
            c_reg  <= bus.cin;
            rem    <= RW'(op_a) + RW'(bus.sw_b) + RW'(bus.cin);
            tens   <= '0;
            busy_q <= 1'b1;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          if (rem_ext >= 8'd10) begin
            rem  <= RW'(rem_ext - 8'd10);
            tens <= tens + 3'd1;
          end else begin
            hex1_q <= seg({1'b0, tens});
            hex0_q <= seg(rem_ext[3:0]);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= SHOW;
          end
        end
        SHOW: begin
          if (press) state <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

  // Conversion never loses value: remainder plus ten per tens step always equals the captured sum
  conv_invariant: assert property (@(posedge clock) disable iff (!resetn)
    (state != CONVERT) ||
    (8'(op_a) + 8'(op_b) + 8'(c_reg) == rem_ext + 8'(tens) * 8'd10));

endmodule

// File: tb/tb_adder_display_sequencer.sv
// Randomised bench for adder_display_sequencer against a digit-arithmetic reference model.
// Latency: checks result after each full A/B/convert sequence.
// Backpressure: n/a.
module tb_adder_display_sequencer;

  localparam int W  = 5;
  localparam int DB = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  adder_display_sequencer_if #(.WIDTH(W)) bus ();

  adder_display_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Cumulative event counters, sampled on the falling edge
  int done_total = 0;
  int busy_total = 0;
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_total++;
    if (bus.busy === 1'b1) busy_total++;
  end

  logic [0:6] seg_tab [10];
  logic [0:6] exp_h1, exp_h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [0:6] model_seg(input int d);
    if (d >= 0 && d <= 9) return seg_tab[d];
    return 7'b1111111;
  endfunction

  task automatic key_for(input logic v, input int n);
    bus.key_n = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_press();
    key_for(1'b0, DB + 6);
    key_for(1'b1, DB + 6);
  endtask

  task automatic wait_phase(input logic [1:0] p, input int max);
    int i = 0;
    while (bus.phase !== p && i < max) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_eq("phase_wait", 32'(bus.phase), 32'(p));
  endtask

  task automatic check_hold(input string tag);
    check_eq({tag, "_hex1"}, 32'(bus.HEX1), 32'(exp_h1));
    check_eq({tag, "_hex0"}, 32'(bus.HEX0), 32'(exp_h0));
  endtask

  // Second half of an operation: B+cin capture, conversion, result, then back to GET_A
  task automatic finish_op(input int a, input int b, input int c);
    int s, d0, b0;
    s = a + b + c;
    bus.sw_a = W'($urandom);
    bus.sw_b = W'(b);
    bus.cin  = c[0];
    d0 = done_total;
    b0 = busy_total;
    do_press();
    wait_phase(2'd3, 100);
    exp_h1 = model_seg(s / 10);
    exp_h0 = model_seg(s % 10);
    check_hold("res");
    check_eq("done_pulses", 32'(done_total - d0), 32'd1);
    check_eq("busy_cycles", 32'(busy_total - b0), 32'(s / 10 + 1));
    bus.sw_b = W'($urandom);
    bus.cin  = 1'($urandom);
    do_press();
    check_eq("show_to_a", 32'(bus.phase), 32'd0);
    check_hold("after_show");
  endtask

  task automatic run_op(input int a, input int b, input int c);
    check_eq("idle_phase", 32'(bus.phase), 32'd0);
    bus.sw_a = W'(a);
    do_press();
    check_eq("a_phase", 32'(bus.phase), 32'd1);
    check_hold("a_hold");
    finish_op(a, b, c);
  endtask

  initial begin
    int d0, b0;
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
    seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
    seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;
    exp_h1 = 7'b1111111;
    exp_h0 = 7'b1111111;

    bus.key_n = 1'b1;
    bus.sw_a  = '0;
    bus.sw_b  = '0;
    bus.cin   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_hold("rst");
    check_eq("rst_phase", 32'(bus.phase), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_hold("idle100");
    check_eq("idle_phase100", 32'(bus.phase), 32'd0);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    check_eq("idle_done", 32'(done_total), 32'd0);

    // Short glitches are rejected, a long press is accepted once
    bus.sw_a = W'(3);
    for (int i = 0; i < 5; i++) begin
      key_for(1'b0, DB - 1);
      key_for(1'b1, DB + 4);
    end
    check_eq("glitch_phase", 32'(bus.phase), 32'd0);
    key_for(1'b0, DB + 5);
    key_for(1'b1, DB + 6);
    check_eq("long_press_phase", 32'(bus.phase), 32'd1);
    finish_op(3, 4, 1);

    // 7 + 7 + 1 = 15
    run_op(7, 7, 1);

    // 31 + 31 + 1 = 63 with a second press landing mid-conversion
    bus.sw_a = W'(31);
    do_press();
    check_eq("max_a_phase", 32'(bus.phase), 32'd1);
    bus.sw_b = W'(31);
    bus.cin  = 1'b1;
    d0 = done_total;
    b0 = busy_total;
    key_for(1'b0, DB);
    key_for(1'b1, DB);
    key_for(1'b0, DB);
    key_for(1'b1, 20);
    wait_phase(2'd3, 50);
    exp_h1 = model_seg(6);
    exp_h0 = model_seg(3);
    check_hold("max");
    check_eq("max_busy_cycles", 32'(busy_total - b0), 32'd7);
    check_eq("max_done", 32'(done_total - d0), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("max_still_show", 32'(bus.phase), 32'd3);
    do_press();
    check_eq("max_to_a", 32'(bus.phase), 32'd0);

    // Reset during conversion blanks the display and drops the result
    bus.sw_a = W'(31);
    do_press();
    bus.sw_b = W'(31);
    bus.cin  = 1'b1;
    d0 = done_total;
    bus.key_n = 1'b0;
    for (int i = 0; i < 40 && bus.busy !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("busy_seen", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_h1 = 7'b1111111;
    exp_h0 = 7'b1111111;
    check_hold("abort");
    check_eq("abort_phase", 32'(bus.phase), 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    bus.key_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_no_done", 32'(done_total - d0), 32'd0);
    run_op(5, 6, 0);

    // Random operands
    for (int i = 0; i < 12; i++) begin
      run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
